fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the single write port of one `fifo` instance among `NUM_REQ` producers. It sits between the producers and the `fifo` write side: it selects one requester per cycle and drives the FIFO's `wr_en`/`data_in`. It honours `full` backpressure so that no write is ever issued into a full FIFO. An optional burst-lock mode keeps a requester's grant for several consecutive beats.

---
 rtl/fifo_arb_pkg.sv | 38 +++
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/rr_prio_enc.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO port arbiters.
// Holds the burst FSM state type and a round-robin pick function.
package fifo_arb_pkg;

   localparam int DEF_FIFO_WIDTH = 8;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int MAX_REQ        = 16;

   typedef enum logic {IDLE, LOCK} arb_state_e;

   // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [3:0]         ptr,
                                                  input int                 n);
      logic [MAX_REQ-1:0] rot;
      logic [MAX_REQ-1:0] pick;
      logic [3:0]         idx;
      bit                 found;
      rot   = '0;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (i < n) begin
            idx    = 4'((int'(ptr) + i) % n);
            rot[i] = req[idx];
         end
      end
      for (int i = 0; i < MAX_REQ; i++) begin
         if (!found && (i < n) && rot[i]) begin
            idx       = 4'((int'(ptr) + i) % n);
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side bundle of the FIFO write arbiter: requests, data, backpressure
// and the resulting grant / FIFO write signals.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = fifo_arb_pkg::DEF_FIFO_WIDTH
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
   logic                          full;
   logic [NUM_REQ-1:0]            gnt;
   logic                          wr_en;
   logic [FIFO_WIDTH-1:0]         data_in;
   logic [$clog2(NUM_REQ)-1:0]    owner;

   modport master (
      output req, req_data, full,
      input  gnt, wr_en, data_in, owner
   );

   modport slave (
      input  req, req_data, full,
      output gnt, wr_en, data_in, owner
   );
endinterface

// File: rtl/rr_prio_enc.sv
// Masked round-robin priority encoder: one-hot pick of the first request at or
// above rr_ptr, wrapping to the lowest request when none lie above it.
module rr_prio_enc #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N-1:0]     gnt,
   output logic             valid
);
   localparam logic [N-1:0] ONE = N'(1);

   logic [N-1:0] mask;
   logic [N-1:0] masked;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mask
         assign mask[gi] = (PTR_W'(gi) >= rr_ptr);
      end
   endgenerate

   assign masked = req & mask;
   // x & -x isolates the lowest set bit.
   assign gnt    = (|masked) ? (masked & (~masked + ONE)) : (req & (~req + ONE));
   assign valid  = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_BURST_EN to let a grant hold for up to BURST_LEN beats.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int BURST_LEN  = 4
) (
   input logic              clk,
   input logic              rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_REQ);

   generate
      if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_param
         $error("fifo_wr_arbiter: NUM_REQ must be 2..16 and BURST_LEN 1..16");
      end
   endgenerate

   logic [PTR_W-1:0]      rr_ptr_reg, rr_ptr_next;
   logic [PTR_W-1:0]      owner_reg, owner_next;
   logic [NUM_REQ-1:0]    rr_gnt;
   logic                  rr_valid;
   logic [NUM_REQ-1:0]    gnt_core;
   logic [NUM_REQ-1:0]    gnt_out;
   logic [PTR_W-1:0]      gnt_idx;
   logic                  accept;
   logic [FIFO_WIDTH-1:0] slice_sel [NUM_REQ];
   logic [FIFO_WIDTH-1:0] data_mux;

   rr_prio_enc #(.N(NUM_REQ), .PTR_W(PTR_W)) u_enc (
      .req    (bus.req),
      .rr_ptr (rr_ptr_reg),
      .gnt    (rr_gnt),
      .valid  (rr_valid)
   );

`ifdef FIFO_WR_ARB_BURST_EN
   localparam int BEAT_W = $clog2(BURST_LEN + 1);

   arb_state_e        state_reg, state_next;
   logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
   logic              lock_hold;

   // A lock whose owner has dropped req falls back to normal arbitration.
   assign lock_hold = (state_reg == LOCK) && bus.req[owner_reg];

   always_comb begin
      gnt_core = '0;
      if (!bus.full) begin
         if (lock_hold) begin
            gnt_core[owner_reg] = 1'b1;
         end else if (rr_valid) begin
            gnt_core = rr_gnt;
         end
      end
   end
`else
   always_comb begin
      gnt_core = '0;
      if (!bus.full && rr_valid) begin
         gnt_core = rr_gnt;
      end
   end
`endif

   assign accept = |gnt_core;

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_core[i]) gnt_idx = PTR_W'(i);
      end
   end

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      owner_next  = owner_reg;
      if (accept) begin
         rr_ptr_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
         owner_next  = gnt_idx;
      end
   end

`ifdef FIFO_WR_ARB_BURST_EN
   always_comb begin
      state_next    = state_reg;
      beat_cnt_next = beat_cnt_reg;
      if (accept) begin
         if (lock_hold) begin
            if (beat_cnt_reg == BEAT_W'(BURST_LEN - 1)) begin
               state_next    = IDLE;
               beat_cnt_next = '0;
            end else begin
               beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
            end
         end else if (BURST_LEN > 1) begin
            state_next    = LOCK;
            beat_cnt_next = BEAT_W'(1);
         end else begin
            state_next    = IDLE;
            beat_cnt_next = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         beat_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         beat_cnt_reg <= beat_cnt_next;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_reg <= '0;
         owner_reg  <= '0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         owner_reg  <= owner_next;
      end
   end

   // Outputs are forced low for the whole reset pulse, not just after an edge.
   assign gnt_out = rst ? '0 : gnt_core;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign slice_sel[gi] = bus.req_data[gi*FIFO_WIDTH +: FIFO_WIDTH] & {FIFO_WIDTH{gnt_out[gi]}};
      end
   endgenerate

   always_comb begin
      data_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         data_mux = data_mux | slice_sel[i];
      end
   end

   assign bus.gnt     = gnt_out;
   assign bus.wr_en   = |gnt_out;
   assign bus.data_in = data_mux;
   assign bus.owner   = owner_reg;

endmodule
